// File: rtl/alu_pkg.sv
// Shared constants for the ALU control decoder and multiply/divide sequencer:
// ALU op codes, funct and alu_op encodings, and the MDU FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_NOR     = 4'b1100;
  localparam logic [3:0] OP_SLL     = 4'b1110;
  localparam logic [3:0] OP_SRL     = 4'b1101;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_mdu_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: shift-add multiply or restoring divide on operand
// magnitudes, one step per cycle, with sign correction applied combinationally on the result.
module mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc_hi: product high half / partial remainder; acc_lo: multiplier / quotient shift register
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand, raw_a;
  logic               neg_a, neg_b, div_mode;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum, shifted;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    sgn_a = is_signed & a[WIDTH-1];
    sgn_b = is_signed & b[WIDTH-1];
    mag_a = sgn_a ? (~a + 1'b1) : a;
    mag_b = sgn_b ? (~b + 1'b1) : b;
    sum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    shifted  = {acc_hi, acc_lo[WIDTH-1]};
    fits     = shifted >= {1'b0, mcand};
    // The remainder is always below the divisor, so the low WIDTH bits are exact
    rem_next = shifted[WIDTH-1:0] - mcand;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      raw_a    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc_hi   <= '0;
      acc_lo   <= is_div ? mag_a : mag_b;
      mcand    <= is_div ? mag_b : mag_a;
      raw_a    <= a;
      neg_a    <= sgn_a;
      neg_b    <= sgn_b;
      div_mode <= is_div;
    end else if (step) begin
      if (div_mode) begin
        acc_hi <= fits ? rem_next : shifted[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], fits};
      end else begin
        acc_hi <= sum[WIDTH:1];
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (neg_a ^ neg_b) ? (~prod + 1'b1) : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_mode) begin
      if (mcand == '0) begin
        res_lo = '1;
        res_hi = raw_a;
      end else begin
        res_lo = (neg_a ^ neg_b) ? (~acc_lo + 1'b1) : acc_lo;
        res_hi = neg_a ? (~acc_hi + 1'b1) : acc_hi;
      end
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus the sequencer for the iterative multiply/divide unit:
// FSM, iteration counter, architectural HI/LO and the EX-stage stall.
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       op,
  output logic             illegal,
  output logic             stall,
  output logic             mdu_rsel,
  output logic [WIDTH-1:0] mdu_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state;
  logic [CNT_W-1:0] counter;
  logic             is_funct, mdu_op, mf_op, mthi, mtlo, busy;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    op      = OP_ILLEGAL;
    illegal = 1'b1;
    case (alu_op)
      ALUOP_ADD: begin op = OP_ADD; illegal = 1'b0; end
      ALUOP_SUB: begin op = OP_SUB; illegal = 1'b0; end
      ALUOP_FUNCT: begin
        illegal = 1'b0;
        case (funct)
          F_AND: op = OP_AND;
          F_OR:  op = OP_OR;
          F_ADD: op = OP_ADD;
          F_SUB: op = OP_SUB;
          F_SLT: op = OP_SLT;
          F_NOR: op = OP_NOR;
          F_SLL: op = OP_SLL;
          F_SRL: op = OP_SRL;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: op = OP_ADD;
          default: begin op = OP_ILLEGAL; illegal = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    is_funct  = issue & (alu_op == ALUOP_FUNCT);
    mdu_op    = is_funct & is_mdu_funct(funct);
    mf_op     = is_funct & ((funct == F_MFHI) | (funct == F_MFLO));
    mthi      = is_funct & (funct == F_MTHI);
    mtlo      = is_funct & (funct == F_MTLO);
    busy      = (state == ST_RUN) | (state == ST_FIX);
    // HI/LO accesses during RUN/FIX are already held off by busy
    stall     = ((state == ST_IDLE) & mdu_op) | busy;
    mdu_rsel  = mf_op & ~busy;
    mdu_rdata = (funct == F_MFHI) ? hi : lo;
  end

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     ((state == ST_IDLE) & mdu_op),
    .step      (state == ST_RUN),
    .is_div    (funct[1]),
    .is_signed (~funct[0]),
    .a         (rs_val),
    .b         (rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mdu_op) begin
            counter <= CNT_W'(WIDTH);
            state   <= ST_RUN;
          end else begin
            if (mthi) hi <= rs_val;
            if (mtlo) lo <= rs_val;
          end
        end
        ST_RUN: begin
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_DONE;
        end
        // The held MDU instruction retires here; it is not captured again
        ST_DONE: begin
          if (mthi) hi <= rs_val;
          if (mtlo) lo <= rs_val;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Scoreboard bench for alu_control_mdu: the driver pushes expected results from a 64-bit
// arithmetic reference model; a negedge monitor pops and compares as the DUT presents them.
module tb_alu_control_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic [3:0]   op;
  logic         illegal, stall, mdu_rsel;
  logic [W-1:0] mdu_rdata, hi, lo;

  always #5 clk = ~clk;

  alu_control_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .issue(issue), .alu_op(alu_op), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .op(op), .illegal(illegal), .stall(stall),
    .mdu_rsel(mdu_rsel), .mdu_rdata(mdu_rdata), .hi(hi), .lo(lo)
  );

  localparam int K_RST = 0, K_MDU = 1, K_MF = 2, K_DEC = 3;

  typedef struct {
    int           kind;
    int           id;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic [W-1:0] e_rdata;
    logic [3:0]   e_op;
    logic         e_ill;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           txn_id = 0;
  logic         probe = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           run_len = 0;
  bit           rst_seen = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn %0d actual %h required %h", nm, id, act, req);
    end
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    ok = 0;
    e = '{default: '0};
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event kind %0d actual none-queued required queued", kind);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_order txn %0d actual kind %0d required kind %0d", e.id, kind, e.kind);
      end else ok = 1;
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural definitions
  function automatic void ref_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint     sa, sb, sq, sr;
    logic [63:0] ua, ub, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    rh = '0; rl = '0;
    case (f)
      6'd24: begin r64 = 64'(sa * sb); rh = r64[63:32]; rl = r64[31:0]; end
      6'd25: begin r64 = ua * ub;      rh = r64[63:32]; rl = r64[31:0]; end
      6'd26, 6'd27: begin
        if (b == '0) begin
          rl = '1; rh = a;
        end else if (f == 6'd26) begin
          sq = sa / sb; sr = sa % sb;
          rl = sq[31:0]; rh = sr[31:0];
        end else begin
          r64 = ua / ub; rl = r64[31:0];
          r64 = ua % ub; rh = r64[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void ref_decode(input logic [1:0] a, input logic [5:0] f,
                                     output logic [3:0] o, output logic il);
    o = 4'b1111; il = 1'b1;
    if (a == 2'b00) begin o = 4'b0010; il = 1'b0; end
    else if (a == 2'b01) begin o = 4'b0110; il = 1'b0; end
    else if (a == 2'b10) begin
      il = 1'b0;
      case (f)
        6'd36: o = 4'b0000;
        6'd37: o = 4'b0001;
        6'd32: o = 4'b0010;
        6'd34: o = 4'b0110;
        6'd42: o = 4'b0111;
        6'd39: o = 4'b1100;
        6'd0:  o = 4'b1110;
        6'd2:  o = 4'b1101;
        6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: o = 4'b0010;
        default: begin o = 4'b1111; il = 1'b1; end
      endcase
    end
  endfunction

  // Monitor: every presented result pops one expectation
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst) begin
      run_len = 0;
      if (!rst_seen) begin
        rst_seen = 1;
        take(K_RST, e, ok);
        if (ok) begin
          chk("rst_stall", e.id, 64'(stall), 64'd0);
          chk("rst_rsel", e.id, 64'(mdu_rsel), 64'd0);
          chk("rst_hi", e.id, 64'(hi), 64'd0);
          chk("rst_lo", e.id, 64'(lo), 64'd0);
          $display("txn %0d reset stall=%0d hi=%h lo=%h", e.id, stall, hi, lo);
        end
      end
    end else begin
      rst_seen = 0;
      if (stall) run_len++;
      else if (run_len > 0) begin
        take(K_MDU, e, ok);
        if (ok) begin
          chk("mdu_hi", e.id, 64'(hi), 64'(e.e_hi));
          chk("mdu_lo", e.id, 64'(lo), 64'(e.e_lo));
          chk("stall_cycles", e.id, 64'(run_len), 64'(W + 2));
          $display("txn %0d mdu hi=%h lo=%h stall_cycles=%0d", e.id, hi, lo, run_len);
        end
        run_len = 0;
      end
      if (mdu_rsel) begin
        take(K_MF, e, ok);
        if (ok) begin
          chk("mf_rdata", e.id, 64'(mdu_rdata), 64'(e.e_rdata));
          chk("mf_stall", e.id, 64'(stall), 64'd0);
          $display("txn %0d mf rdata=%h", e.id, mdu_rdata);
        end
      end
      if (probe) begin
        take(K_DEC, e, ok);
        if (ok) begin
          chk("dec_op", e.id, 64'(op), 64'(e.e_op));
          chk("dec_illegal", e.id, 64'(illegal), 64'(e.e_ill));
          $display("txn %0d decode alu_op=%b funct=%0d op=%b illegal=%0d", e.id, alu_op, funct, op, illegal);
        end
      end
    end
  end

  // Advance until the presented instruction retires (an edge with stall low)
  task automatic wait_retire(input int id, input bit scramble);
    logic s;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      n++;
      if (scramble) begin rs_val = $urandom; rt_val = $urandom; end
    end while (s && n < 200);
    checks++;
    if (s) begin
      errors++;
      $display("FAIL retire_timeout txn %0d actual stall 1 required 0", id);
    end
  endtask

  task automatic push_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] rh, rl;
    ref_mdu(f, a, b, rh, rl);
    txn_id++;
    e = '{default: '0};
    e.kind = K_MDU; e.id = txn_id; e.e_hi = rh; e.e_lo = rl;
    sb_q.push_back(e);
    m_hi = rh; m_lo = rl;
    issue = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
  endtask

  task automatic push_mf(input logic [5:0] f);
    exp_t e;
    txn_id++;
    e = '{default: '0};
    e.kind = K_MF; e.id = txn_id; e.e_rdata = (f == 6'd16) ? m_hi : m_lo;
    sb_q.push_back(e);
    issue = 1'b1; alu_op = 2'b10; funct = f;
  endtask

  task automatic do_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit scr);
    push_mdu(f, a, b);
    wait_retire(txn_id, scr);
    issue = 1'b0;
  endtask

  task automatic do_mf(input logic [5:0] f);
    push_mf(f);
    wait_retire(txn_id, 1'b0);
    issue = 1'b0;
  endtask

  task automatic do_mt(input logic [5:0] f, input logic [W-1:0] v);
    issue = 1'b1; alu_op = 2'b10; funct = f; rs_val = v;
    if (f == 6'd17) m_hi = v; else m_lo = v;
    txn_id++;
    wait_retire(txn_id, 1'b0);
    issue = 1'b0;
  endtask

  task automatic do_dec(input logic [1:0] a, input logic [5:0] f);
    exp_t e;
    txn_id++;
    e = '{default: '0};
    e.kind = K_DEC; e.id = txn_id;
    ref_decode(a, f, e.e_op, e.e_ill);
    sb_q.push_back(e);
    issue = 1'b1; alu_op = a; funct = f;
    probe = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    probe = 1'b0;
    issue = 1'b0;
  endtask

  task automatic do_reset();
    exp_t e;
    txn_id++;
    e = '{default: '0};
    e.kind = K_RST; e.id = txn_id;
    sb_q.push_back(e);
    issue = 1'b0;
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] ra;
    logic [5:0] rf;
    issue = 1'b0; alu_op = 2'b00; funct = '0; rs_val = '0; rt_val = '0;
    rst = 1'b0;
    #1;
    do_reset();

    do_dec(2'b10, 6'd42);
    do_dec(2'b11, 6'd32);
    do_dec(2'b10, 6'd5);
    do_dec(2'b00, 6'd24);
    do_dec(2'b01, 6'd0);

    do_mdu(6'd24, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_mdu(6'd25, 32'hFFFF_FFFD, 32'd7, 1'b1);
    do_mdu(6'd27, 32'd100, 32'd7, 1'b1);
    do_mdu(6'd26, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_mdu(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_mdu(6'd26, 32'd5, 32'd0, 1'b0);
    do_mf(6'd16);
    do_mf(6'd18);

    // MFLO arrives while the multiply is still running
    push_mdu(6'd24, 32'd1000, 32'hFFFF_FFF0);
    @(posedge clk);
    #1;
    push_mf(6'd18);
    wait_retire(txn_id, 1'b0);
    issue = 1'b0;

    do_mt(6'd17, 32'h0000_1234);
    do_mf(6'd16);
    do_mt(6'd19, 32'hCAFE_F00D);
    do_mf(6'd18);

    // Reset in the middle of RUN discards the operation
    issue = 1'b1; alu_op = 2'b10; funct = 6'd25; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
    repeat (11) @(posedge clk);
    #1;
    do_reset();
    do_mdu(6'd24, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_mdu(6'(24 + $urandom_range(0, 3)), pick_val(), pick_val(), 1'b1);
      if (i % 4 == 1) do_mf($urandom_range(0, 1) ? 6'd16 : 6'd18);
      if (i % 6 == 3) do_mt($urandom_range(0, 1) ? 6'd17 : 6'd19, $urandom);
    end
    for (int i = 0; i < 16; i++) begin
      ra = 2'($urandom_range(0, 3));
      rf = 6'($urandom_range(0, 63));
      if (ra == 2'b10 && (rf inside {[6'd16:6'd19], [6'd24:6'd27]})) rf = rf ^ 6'h20;
      do_dec(ra, rf);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 0, 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
